lut_sweep: RTL



---
 rtl/lut_sweep.sv | 121 ++++++++++++
 1 files changed

// File: rtl/lut_sweep.sv
// lut_sweep: programmable N-input truth table with single evaluation and exhaustive sweep.
// Optional feature macro SWEEP_SIG_EN enables the ones_count sweep signature counter.
module lut_sweep #(
  parameter int N = 3,
  parameter logic [2**N-1:0] INIT = {2**N{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  input  logic         load_bit,
  output logic         load_ready,
  input  logic         eval,
  input  logic [N-1:0] in_vec,
  input  logic         start,
  output logic         f,
  output logic         f_valid,
  output logic [N-1:0] sweep_idx,
  output logic         busy,
  output logic         done,
  output logic [N:0]   ones_count
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state_q;
  logic [2**N-1:0] table_q;
  logic [N-1:0]    loadPtr_q;
  logic [N-1:0]    idx_q;
  logic [N-1:0]    sweepIdx_q;
  logic            f_q;
  logic            fValid_q;
  logic            busy_q;
  logic            done_q;
  logic            sweepBit;
  logic            lastIdx;

  assign sweepBit   = table_q[idx_q];
  assign lastIdx    = (idx_q == {N{1'b1}});
  assign load_ready = (state_q == IDLE) && !start && !eval;

  // Only one IDLE request is honoured per cycle: start, then eval, then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      table_q    <= INIT;
      loadPtr_q  <= '0;
      idx_q      <= '0;
      sweepIdx_q <= '0;
      f_q        <= 1'b0;
      fValid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fValid_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SWEEP;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end else if (eval) begin
            f_q        <= table_q[in_vec];
            sweepIdx_q <= in_vec;
            fValid_q   <= 1'b1;
          end else if (load_valid) begin
            table_q[loadPtr_q] <= load_bit;
            loadPtr_q          <= loadPtr_q + N'(1);
          end
        end
        SWEEP: begin
          f_q        <= sweepBit;
          sweepIdx_q <= idx_q;
          fValid_q   <= 1'b1;
          if (lastIdx) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + N'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign f         = f_q;
  assign f_valid   = fValid_q;
  assign sweep_idx = sweepIdx_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef SWEEP_SIG_EN
  logic [N:0] onesCount_q;
  logic [N:0] onesCount_d;

  // Signature is cleared on sweep start and frozen once the sweep ends.
  always_comb begin
    onesCount_d = onesCount_q;
    if (state_q == IDLE && start) begin
      onesCount_d = '0;
    end else if (state_q == SWEEP && sweepBit) begin
      onesCount_d = onesCount_q + (N+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      onesCount_q <= '0;
    end else begin
      onesCount_q <= onesCount_d;
    end
  end

  assign ones_count = onesCount_q;
`else
  assign ones_count = '0;
`endif

endmodule
